// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement queue for an out-of-order core. Instructions are
// allocated at the tail on issue, marked ready by the common data bus (CDB)
// and retired from the head one per cycle. A retiring non-branch instruction
// produces a registered register-file write; a retiring conditional branch
// whose resolved direction differs from its prediction flushes the whole
// buffer and requests a fetch redirect.
//
// Index 0 is reserved as "no dependency", so the buffer holds
// N = 2**ROB_WIDTH - 1 entries at indices 1..N, wrapping from N back to 1.
//
// Optional feature (compile-time macro):
//   ROB_CDB_BYPASS_EN - operand queries also see the CDB result broadcast in
//                       the same cycle; when undefined, queries reflect
//                       stored state only (result visible one cycle later).
//
// Ports:
//   clk_in, rst_in, rdy_in         clock, async active-high reset, global stall
//   issue_*                        new instruction (valid, rd, branch info)
//   rob_full, rob_next_index       allocation status / index the next issue gets
//   cdb_*                          execution-result broadcast
//   query{1,2}_index/_ready/_val   combinational operand lookups
//   rob_to_rf_*                    registered commit to the register file
//   clr_out, clr_pc                one-cycle flush pulse and redirect PC
// ----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,

   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd_id,
   input  logic                 issue_is_branch,
   input  logic                 issue_pred_taken,
   input  logic [31:0]          issue_alt_pc,
   output logic                 rob_full,
   output logic [ROB_WIDTH-1:0] rob_next_index,

   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob_index,
   input  logic [31:0]          cdb_val,
   input  logic                 cdb_taken,

   input  logic [ROB_WIDTH-1:0] query1_index,
   input  logic [ROB_WIDTH-1:0] query2_index,
   output logic                 query1_ready,
   output logic [31:0]          query1_val,
   output logic                 query2_ready,
   output logic [31:0]          query2_val,

   output logic                 rob_to_rf_ready,
   output logic [4:0]           rob_to_rf_reg_id,
   output logic [31:0]          rob_to_rf_reg_val,
   output logic [ROB_WIDTH-1:0] rob_to_rf_rob_index,

   output logic                 clr_out,
   output logic [31:0]          clr_pc
);

   localparam int DEPTH = 1 << ROB_WIDTH;
   localparam int N     = DEPTH - 1;

   typedef logic [ROB_WIDTH-1:0] idx_t;

   localparam idx_t FIRST_IDX = idx_t'(1);
   localparam idx_t LAST_IDX  = idx_t'(N);

   // Circular advance over 1..N; index 0 is never produced.
   function automatic idx_t advance(input idx_t i);
      return (i == LAST_IDX) ? FIRST_IDX : i + FIRST_IDX;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   // Control bits per entry (reset); slot 0 is allocated in the vectors but
   // never set, which makes index-0 lookups fall out as "not busy".
   logic [DEPTH-1:0] busy, busy_nxt;
   logic [DEPTH-1:0] done, done_nxt;

   idx_t head, head_nxt;
   idx_t tail, tail_nxt;
   idx_t count, count_nxt;

   // Payload per entry (not reset).
   logic [4:0]       rd_mem  [DEPTH];
   logic [31:0]      alt_mem [DEPTH];
   logic [31:0]      val_mem [DEPTH];
   logic [DEPTH-1:0] br_mem;
   logic [DEPTH-1:0] pt_mem;
   logic [DEPTH-1:0] tk_mem;

   // -------------------------------------------------------------------------
   // Per-cycle decisions
   // -------------------------------------------------------------------------
   logic issue_fire;
   logic cdb_hit;
   logic head_commit;
   logic rf_write;
   logic mispredict;

   assign rob_full       = (count == LAST_IDX);
   assign rob_next_index = tail;

   // Issue is refused while full even if the head retires this cycle, and
   // during the flush cycle so nothing allocated can survive the redirect.
   assign issue_fire  = issue_valid && !rob_full && !clr_out && rdy_in;

   // Only a live (busy) entry may take a result; index 0 is never busy.
   // Results arriving during the flush cycle belong to squashed work.
   assign cdb_hit     = cdb_valid && (cdb_rob_index != '0) &&
                        busy[cdb_rob_index] && !clr_out;

   // Retirement looks at the stored ready bit only, so the earliest commit
   // is the edge after the CDB write.
   assign head_commit = busy[head] && done[head];
   assign rf_write    = head_commit && !br_mem[head];
   assign mispredict  = head_commit && br_mem[head] &&
                        (tk_mem[head] != pt_mem[head]);

   // -------------------------------------------------------------------------
   // Next-state computation
   // -------------------------------------------------------------------------
   // NOTE: every variable assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      busy_nxt  = busy;
      done_nxt  = done;
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;

      if (cdb_hit) begin
         done_nxt[cdb_rob_index] = 1'b1;
      end

      // The retiring slot is freed before the issue write below; the two can
      // never address the same slot because issue is blocked when full.
      if (head_commit) begin
         busy_nxt[head] = 1'b0;
         done_nxt[head] = 1'b0;
         head_nxt       = advance(head);
      end

      if (issue_fire) begin
         busy_nxt[tail] = 1'b1;
         done_nxt[tail] = 1'b0;
         tail_nxt       = advance(tail);
      end

      case ({issue_fire, head_commit})
         2'b10:   count_nxt = count + FIRST_IDX;
         2'b01:   count_nxt = count - FIRST_IDX;
         default: count_nxt = count;
      endcase

      // A mispredicted branch squashes everything younger than itself,
      // including an instruction issued in the same cycle.
      if (mispredict) begin
         busy_nxt  = '0;
         done_nxt  = '0;
         head_nxt  = FIRST_IDX;
         tail_nxt  = FIRST_IDX;
         count_nxt = '0;
      end
   end

   // -------------------------------------------------------------------------
   // Control registers and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy                <= '0;
         done                <= '0;
         head                <= FIRST_IDX;
         tail                <= FIRST_IDX;
         count               <= '0;
         rob_to_rf_ready     <= 1'b0;
         rob_to_rf_reg_id    <= '0;
         rob_to_rf_reg_val   <= '0;
         rob_to_rf_rob_index <= '0;
         clr_out             <= 1'b0;
         clr_pc              <= '0;
      end else if (rdy_in) begin
         busy  <= busy_nxt;
         done  <= done_nxt;
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count_nxt;

         // Pulses: high only after a qualifying commit; data fields hold.
         rob_to_rf_ready <= rf_write;
         if (rf_write) begin
            rob_to_rf_reg_id    <= rd_mem[head];
            rob_to_rf_reg_val   <= val_mem[head];
            rob_to_rf_rob_index <= head;
         end

         clr_out <= mispredict;
         if (mispredict) begin
            clr_pc <= alt_mem[head];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Entry payload
   // -------------------------------------------------------------------------
   // NOTE: payload storage is deliberately not reset; every read of it is
   // qualified by the reset busy/ready bits, so stale contents are never seen.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (issue_fire) begin
            rd_mem[tail]  <= issue_rd_id;
            alt_mem[tail] <= issue_alt_pc;
            val_mem[tail] <= '0;
            br_mem[tail]  <= issue_is_branch;
            pt_mem[tail]  <= issue_pred_taken;
            tk_mem[tail]  <= 1'b0;
         end
         if (cdb_hit) begin
            val_mem[cdb_rob_index] <= cdb_val;
            tk_mem[cdb_rob_index]  <= cdb_taken;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Operand queries
   // -------------------------------------------------------------------------
   always_comb begin
      query1_ready = busy[query1_index] && done[query1_index];
      query1_val   = query1_ready ? val_mem[query1_index] : '0;
      query2_ready = busy[query2_index] && done[query2_index];
      query2_val   = query2_ready ? val_mem[query2_index] : '0;
`ifdef ROB_CDB_BYPASS_EN
      // Forward a result being broadcast this cycle to a matching lookup.
      if (cdb_hit && (query1_index == cdb_rob_index)) begin
         query1_ready = 1'b1;
         query1_val   = cdb_val;
      end
      if (cdb_hit && (query2_index == cdb_rob_index)) begin
         query2_ready = 1'b1;
         query2_val   = cdb_val;
      end
`else
      // Queries reflect stored state only; a broadcast result becomes
      // visible the cycle after its CDB write.
`endif
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer (ROB_WIDTH = 4, 15 entries).
// A queue of in-flight instructions models the buffer; expected outputs are
// derived from that queue each cycle. Directed scenarios pin the model with
// literal values, then a randomized phase exercises issue/CDB/commit/flush.
// ----------------------------------------------------------------------------
module tb_reorder_buffer;

   localparam int W = 4;
   localparam int N = (1 << W) - 1;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          issue_valid;
   logic [4:0]    issue_rd_id;
   logic          issue_is_branch;
   logic          issue_pred_taken;
   logic [31:0]   issue_alt_pc;
   logic          rob_full;
   logic [W-1:0]  rob_next_index;
   logic          cdb_valid;
   logic [W-1:0]  cdb_rob_index;
   logic [31:0]   cdb_val;
   logic          cdb_taken;
   logic [W-1:0]  query1_index;
   logic [W-1:0]  query2_index;
   logic          query1_ready;
   logic [31:0]   query1_val;
   logic          query2_ready;
   logic [31:0]   query2_val;
   logic          rob_to_rf_ready;
   logic [4:0]    rob_to_rf_reg_id;
   logic [31:0]   rob_to_rf_reg_val;
   logic [W-1:0]  rob_to_rf_rob_index;
   logic          clr_out;
   logic [31:0]   clr_pc;

   reorder_buffer #(.ROB_WIDTH(W)) dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .rdy_in              (rdy_in),
      .issue_valid         (issue_valid),
      .issue_rd_id         (issue_rd_id),
      .issue_is_branch     (issue_is_branch),
      .issue_pred_taken    (issue_pred_taken),
      .issue_alt_pc        (issue_alt_pc),
      .rob_full            (rob_full),
      .rob_next_index      (rob_next_index),
      .cdb_valid           (cdb_valid),
      .cdb_rob_index       (cdb_rob_index),
      .cdb_val             (cdb_val),
      .cdb_taken           (cdb_taken),
      .query1_index        (query1_index),
      .query2_index        (query2_index),
      .query1_ready        (query1_ready),
      .query1_val          (query1_val),
      .query2_ready        (query2_ready),
      .query2_val          (query2_val),
      .rob_to_rf_ready     (rob_to_rf_ready),
      .rob_to_rf_reg_id    (rob_to_rf_reg_id),
      .rob_to_rf_reg_val   (rob_to_rf_reg_val),
      .rob_to_rf_rob_index (rob_to_rf_rob_index),
      .clr_out             (clr_out),
      .clr_pc              (clr_pc)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Scoring
   // -------------------------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Behavioural model: ordered list of in-flight instructions
   // -------------------------------------------------------------------------
   typedef struct {
      int          idx;
      logic [4:0]  rd;
      bit          br;
      bit          pt;
      bit          rdy;
      bit          tk;
      logic [31:0] alt;
      logic [31:0] val;
   } ent_t;

   ent_t        mq[$];
   int          m_tail;
   bit          e_rf_ready;
   logic [4:0]  e_rf_id;
   logic [31:0] e_rf_val;
   int          e_rf_idx;
   bit          e_clr;
   logic [31:0] e_clr_pc;

   task automatic model_reset();
      mq.delete();
      m_tail     = 1;
      e_rf_ready = 0;
      e_rf_id    = '0;
      e_rf_val   = '0;
      e_rf_idx   = 0;
      e_clr      = 0;
      e_clr_pc   = '0;
   endtask

   // One clock edge of the buffer's contract, using the inputs present now.
   task automatic model_step();
      ent_t c;
      bit   commit;
      bit   iss;
      bit   flush;
      if (!rdy_in) return;
      commit = (mq.size() > 0) && mq[0].rdy;
      if (commit) c = mq[0];
      iss   = issue_valid && (mq.size() < N) && !e_clr;
      flush = 0;
      if (cdb_valid && cdb_rob_index != 0 && !e_clr) begin
         foreach (mq[i]) begin
            if (mq[i].idx == int'(cdb_rob_index)) begin
               mq[i].rdy = 1;
               mq[i].val = cdb_val;
               mq[i].tk  = cdb_taken;
            end
         end
      end
      e_rf_ready = 0;
      if (commit) begin
         void'(mq.pop_front());
         if (!c.br) begin
            e_rf_ready = 1;
            e_rf_id    = c.rd;
            e_rf_val   = c.val;
            e_rf_idx   = c.idx;
         end else if (c.tk != c.pt) begin
            flush = 1;
         end
      end
      if (flush) begin
         mq.delete();
         m_tail   = 1;
         e_clr    = 1;
         e_clr_pc = c.alt;
      end else begin
         e_clr = 0;
         if (iss) begin
            mq.push_back('{idx: m_tail, rd: issue_rd_id, br: issue_is_branch,
                           pt: issue_pred_taken, rdy: 0, tk: 0,
                           alt: issue_alt_pc, val: '0});
            m_tail = (m_tail == N) ? 1 : m_tail + 1;
         end
      end
   endtask

   task automatic model_query(input logic [W-1:0] q, output bit r,
                              output logic [31:0] v);
      r = 0;
      v = '0;
      foreach (mq[i]) begin
         if (q != 0 && mq[i].idx == int'(q)) begin
            if (mq[i].rdy) begin
               r = 1;
               v = mq[i].val;
            end
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_valid && cdb_rob_index == q && !e_clr) begin
               r = 1;
               v = cdb_val;
            end
`endif
         end
      end
   endtask

   // -------------------------------------------------------------------------
   // Comparison against the model
   // -------------------------------------------------------------------------
   task automatic compare_queries();
      bit          r;
      logic [31:0] v;
      model_query(query1_index, r, v);
      check("query1_ready", query1_ready, r);
      check("query1_val", query1_val, v);
      model_query(query2_index, r, v);
      check("query2_ready", query2_ready, r);
      check("query2_val", query2_val, v);
   endtask

   task automatic compare_outputs();
      check("rob_full", rob_full, (mq.size() == N));
      check("rob_next_index", rob_next_index, m_tail);
      check("rob_to_rf_ready", rob_to_rf_ready, e_rf_ready);
      if (e_rf_ready) begin
         check("rob_to_rf_reg_id", rob_to_rf_reg_id, e_rf_id);
         check("rob_to_rf_reg_val", rob_to_rf_reg_val, e_rf_val);
         check("rob_to_rf_rob_index", rob_to_rf_rob_index, e_rf_idx);
      end
      check("clr_out", clr_out, e_clr);
      if (e_clr) check("clr_pc", clr_pc, e_clr_pc);
   endtask

   // Called at a negedge with the next inputs already driven.
   task automatic tick();
      #1;
      compare_queries();
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      compare_outputs();
   endtask

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic idle();
      rdy_in           = 1;
      issue_valid      = 0;
      issue_rd_id      = '0;
      issue_is_branch  = 0;
      issue_pred_taken = 0;
      issue_alt_pc     = '0;
      cdb_valid        = 0;
      cdb_rob_index    = '0;
      cdb_val          = '0;
      cdb_taken        = 0;
      query1_index     = '0;
      query2_index     = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1;
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 0;
      model_reset();
      compare_outputs();
   endtask

   task automatic issue(input logic [4:0] rd, input bit br, input bit pt,
                        input logic [31:0] alt);
      idle();
      issue_valid      = 1;
      issue_rd_id      = rd;
      issue_is_branch  = br;
      issue_pred_taken = pt;
      issue_alt_pc     = alt;
      tick();
   endtask

   task automatic cdb(input int idx, input logic [31:0] v, input bit tk);
      idle();
      cdb_valid     = 1;
      cdb_rob_index = W'(idx);
      cdb_val       = v;
      cdb_taken     = tk;
      tick();
   endtask

   function automatic logic [W-1:0] pick_idx();
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
         return W'(mq[$urandom_range(0, mq.size() - 1)].idx);
      return W'($urandom_range(0, N));
   endfunction

   // -------------------------------------------------------------------------
   // Test sequence
   // -------------------------------------------------------------------------
   initial begin
      idle();
      rst_in = 1;
      model_reset();
      #2;
      // Reset values while reset is held.
      check("reset rob_to_rf_ready", rob_to_rf_ready, 0);
      check("reset rob_to_rf_reg_id", rob_to_rf_reg_id, 0);
      check("reset rob_to_rf_reg_val", rob_to_rf_reg_val, 0);
      check("reset rob_to_rf_rob_index", rob_to_rf_rob_index, 0);
      check("reset clr_out", clr_out, 0);
      check("reset clr_pc", clr_pc, 0);
      check("reset rob_next_index", rob_next_index, 1);
      check("reset rob_full", rob_full, 0);
      do_reset();

      // Single instruction: issue, complete, retire.
      issue(5'd5, 0, 0, 32'h0);
      cdb(1, 32'h1234, 0);
      idle();
      tick();
      check("lit commit ready", rob_to_rf_ready, 1);
      check("lit commit reg_id", rob_to_rf_reg_id, 5);
      check("lit commit val", rob_to_rf_reg_val, 32'h1234);
      check("lit commit index", rob_to_rf_rob_index, 1);
      tick();
      check("lit commit pulse ends", rob_to_rf_ready, 0);

      // Fill to capacity, refused issue, then wrap after one retirement.
      do_reset();
      for (int i = 0; i < N; i++) issue(5'(i + 1), 0, 0, 32'h0);
      check("lit full", rob_full, 1);
      check("lit full next_index", rob_next_index, 1);
      issue(5'd30, 0, 0, 32'h0);
      check("lit refused issue next_index", rob_next_index, 1);
      cdb(1, 32'hAA, 0);
      // Head retires this edge while an issue is requested: still refused.
      issue(5'd31, 0, 0, 32'h0);
      check("lit refused on commit edge", rob_next_index, 1);
      check("lit entry freed", rob_full, 0);
      issue(5'd29, 0, 0, 32'h0);
      check("lit wrap next_index", rob_next_index, 2);
      check("lit full again", rob_full, 1);

      // Out-of-order completion retires in order.
      do_reset();
      issue(5'd1, 0, 0, 32'h0);
      issue(5'd2, 0, 0, 32'h0);
      cdb(2, 32'h22, 0);
      cdb(1, 32'h11, 0);
      idle();
      tick();
      check("lit order first index", rob_to_rf_rob_index, 1);
      check("lit order first val", rob_to_rf_reg_val, 32'h11);
      tick();
      check("lit order second ready", rob_to_rf_ready, 1);
      check("lit order second index", rob_to_rf_rob_index, 2);

      // Mispredicted branch flushes everything.
      do_reset();
      issue(5'd0, 1, 0, 32'h100);
      for (int i = 0; i < 3; i++) issue(5'(i + 3), 0, 0, 32'h0);
      cdb(1, 32'h0, 1);
      idle();
      tick();
      check("lit flush clr_out", clr_out, 1);
      check("lit flush clr_pc", clr_pc, 32'h100);
      check("lit flush no rf", rob_to_rf_ready, 0);
      // Issue and CDB during the flush cycle are both discarded.
      issue_valid   = 1;
      cdb_valid     = 1;
      cdb_rob_index = 4'd2;
      tick();
      check("lit flush pulse ends", clr_out, 0);
      check("lit flush next_index", rob_next_index, 1);

      // Query timing around a CDB write.
      do_reset();
      for (int i = 0; i < 3; i++) issue(5'(i + 1), 0, 0, 32'h0);
      idle();
      cdb_valid     = 1;
      cdb_rob_index = 4'd3;
      cdb_val       = 32'h77;
      query1_index  = 4'd3;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      check("lit query bypass ready", query1_ready, 1);
      check("lit query bypass val", query1_val, 32'h77);
`else
      check("lit query same-cycle ready", query1_ready, 0);
`endif
      tick();
      idle();
      query1_index = 4'd3;
      #1;
      check("lit query next ready", query1_ready, 1);
      check("lit query next val", query1_val, 32'h77);
      query2_index = 4'd0;
      #1;
      check("lit query idx0 ready", query2_ready, 0);
      tick();

      // Asynchronous reset right after a commit, then a stalled issue.
      do_reset();
      issue(5'd7, 0, 0, 32'h0);
      cdb(1, 32'h55, 0);
      idle();
      tick();
      check("lit pre-reset commit", rob_to_rf_ready, 1);
      #2;
      rst_in = 1;
      #1;
      model_reset();
      check("lit async rf_ready", rob_to_rf_ready, 0);
      check("lit async reg_id", rob_to_rf_reg_id, 0);
      check("lit async reg_val", rob_to_rf_reg_val, 0);
      check("lit async rob_index", rob_to_rf_rob_index, 0);
      check("lit async next_index", rob_next_index, 1);
      rdy_in      = 0;
      issue_valid = 1;
      @(negedge clk_in);
      rst_in = 0;
      tick();
      check("lit stalled issue ignored", rob_next_index, 1);

      // Randomized phase.
      for (int k = 0; k < 3000; k++) begin
         rdy_in           = ($urandom_range(0, 9) != 0);
         issue_valid      = $urandom_range(0, 1);
         issue_rd_id      = 5'($urandom_range(0, 31));
         issue_is_branch  = ($urandom_range(0, 3) == 0);
         issue_pred_taken = $urandom_range(0, 1);
         issue_alt_pc     = $urandom;
         cdb_valid        = ($urandom_range(0, 2) != 0);
         cdb_rob_index    = pick_idx();
         cdb_val          = $urandom;
         cdb_taken        = $urandom_range(0, 1);
         query1_index     = pick_idx();
         query2_index     = pick_idx();
         tick();
         if (k == 1500) begin
            #3;
            rst_in = 1;
            #1;
            model_reset();
            compare_outputs();
            @(negedge clk_in);
            rst_in = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, meaning the entry index width. Index 0 is reserved as "no dependency", so capacity N = 2^ROB_WIDTH - 1 and valid indices are 1..N.
REQ-002 SHALL have clk_in  input  1  system clock; the block uses this single clock.
REQ-003 SHALL have rst_in  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have rdy_in  input  1  global ready; when low, all state and outputs hold.
REQ-005 SHALL have issue_valid  input  1  issue a new instruction this cycle.
REQ-006 SHALL have issue_rd_id  input  5  destination register; 0 means no writeback.
REQ-007 SHALL have issue_is_branch, issue_pred_taken  input  1 each  conditional-branch flag and predicted direction.
REQ-008 SHALL have issue_alt_pc  input  32  redirect PC, used if the prediction proves wrong.
REQ-009 SHALL have rob_full  output  1  no free entry; issue is refused.
REQ-010 SHALL have rob_next_index  output  ROB_WIDTH  index the next issued instruction receives (the tail).
REQ-011 SHALL have cdb_valid, cdb_rob_index, cdb_val, cdb_taken  input  1/ROB_WIDTH/32/1  execution-result broadcast.
REQ-012 SHALL have query1_index, query2_index  input  ROB_WIDTH each  operand lookups.
REQ-013 SHALL have query1_ready/query1_val and query2_ready/query2_val  output  1/32 each  combinational lookup results.
REQ-014 SHALL have rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_index  output  1/5/32/ROB_WIDTH  registered commit to the register file.
REQ-015 SHALL have clr_out  output  1  one-cycle pipeline flush.
REQ-016 SHALL have clr_pc  output  32  PC to fetch from after a flush.

Function
REQ-017 SHALL keep head, tail and count registers. Empty is count==0. rob_full is count==N.
REQ-018 Index advance SHALL be idx+1, except N SHALL wrap to 1. Index 0 is never allocated.
REQ-019 An issue SHALL be accepted only when issue_valid && !rob_full && !clr_out && rdy_in.
REQ-020 An accepted issue SHALL write entry[tail] (busy=1, ready=0, rd, is_branch, pred_taken, alt_pc) and advance tail.
REQ-021 A CDB write with cdb_valid and a busy entry at cdb_rob_index SHALL set ready=1, value=cdb_val and taken=cdb_taken on that edge. A CDB write to a non-busy entry or to index 0 SHALL be ignored.
REQ-022 Commit SHALL occur at an edge where head is busy and ready (at most one per cycle). The earliest commit is the edge after the CDB write.
REQ-023 On a non-branch commit, the next cycle SHALL show rob_to_rf_ready=1 with rd, value and head index. rob_to_rf_ready SHALL be 1 even when rd=0. The head entry is freed and head advances.
REQ-024 On a branch commit with taken==pred_taken, no RF write and no flush SHALL occur; the entry is freed.
REQ-025 On a branch commit with taken!=pred_taken, the next cycle SHALL show clr_out=1 and clr_pc=alt_pc for exactly one cycle. All entries SHALL be cleared, head=tail=1 and count=0. rob_to_rf_ready SHALL stay 0.
REQ-026 Issue and commit in the same cycle SHALL leave count unchanged. Issue SHALL be refused when full, even if a commit frees an entry that cycle.
REQ-027 A CDB write during the clr_out cycle SHALL be discarded.
REQ-028 query_ready SHALL be entry.ready of the queried index. query_val SHALL be entry.value. Index 0 or a non-busy entry SHALL return ready=0 and val=0.
REQ-029 rob_to_rf_ready and clr_out SHALL be single-cycle pulses, deasserted in any cycle without a qualifying commit.

Reset
REQ-030 rst_in SHALL immediately force head=1, tail=1, count=0 and all entries busy=0, ready=0.
REQ-031 rst_in SHALL force rob_to_rf_ready=0, rob_to_rf_reg_id=0, rob_to_rf_reg_val=0, rob_to_rf_rob_index=0, clr_out=0 and clr_pc=0.
REQ-032 A reset mid-operation SHALL discard all in-flight entries, with no partial commit.

Configuration
REQ-033 Macro ROB_CDB_BYPASS_EN: when defined, a query whose index equals cdb_rob_index with cdb_valid high SHALL return ready=1 and val=cdb_val in the same cycle. When undefined, queries reflect stored state only, one cycle later.

Verification
REQ-034 Reset, then issue rd=5 and CDB write idx1 val=0x1234 -> the cycle after the next edge shows rob_to_rf_ready=1, reg_id=5, val=0x1234, rob_index=1.
REQ-035 Issue 15 instructions without CDB writes -> rob_full=1, the 16th issue is ignored and rob_next_index stays 1. Completing idx1 then frees an entry and allocation wraps to index 1.
REQ-036 CDB writes to idx2 then idx1 -> idx1 commits before idx2, in consecutive cycles.
REQ-037 Issue a branch with pred_taken=0 and alt_pc=0x100, then issue 3 more; CDB writes taken=1 to the branch -> clr_out=1 and clr_pc=0x100 for one cycle, then count=0 and rob_next_index=1.
REQ-038 Query idx3 while the CDB writes idx3 val=0x77 -> ready=1 and val=0x77 with ROB_CDB_BYPASS_EN; ready=0 without it, then ready=1 the next cycle.
REQ-039 Assert rst_in asynchronously mid-commit and hold rdy_in=0 across an issue -> outputs clear immediately and the stalled issue is not accepted.
